// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: scan states and width helper shared by the display scan controller
package seg_scan_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GUARD} state_t;
  function automatic int clog2w(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/seg_scan_ctrl_lead_zero_mask.sv
// lead_zero_mask: flags digits that are leading zeros with no decimal point at or above them
module lead_zero_mask
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] disp_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [NUM_DIGITS-1:0]   blank_o
);
  logic run;
  // walk from the most significant digit down; a digit stays dark while everything above it is empty
  always_comb begin
    run = 1'b1;
    blank_o = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run & (disp_i[4*i +: 4] == 4'd0) & ~dp_i[i];
      blank_o[i] = run & (i != 0);
    end
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan with guard gaps, blanking and frame-aligned updates
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int GUARD       = 2,
  parameter int LEAD_BLANK  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [3:0]              bcd_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_start
);
  localparam int CW = clog2w(REFRESH_DIV > GUARD ? REFRESH_DIV : GUARD);
  localparam int IW = clog2w(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         div_q, div_d;
  logic [DW-1:0]         disp_q, disp_d, pend_q, pend_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d, pdp_q, pdp_d, zmask;
  logic                  pv_q, pv_d, fs_q, fs_d;
  logic                  end_show, end_guard, wrap, boundary, lit;
  logic [3:0]            nibs [NUM_DIGITS];
  assign end_show  = div_q == CW'(REFRESH_DIV - 1);
  assign end_guard = div_q == CW'(GUARD - 1);
  assign wrap      = idx_q == IW'(NUM_DIGITS - 1);
  assign boundary  = (state_q == ST_GUARD) && end_guard && wrap;
  // state register; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      div_q   <= '0;
      disp_q  <= '0;
      dp_q    <= '0;
      pend_q  <= '0;
      pdp_q   <= '0;
      pv_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      disp_q  <= disp_d;
      dp_q    <= dp_d;
      pend_q  <= pend_d;
      pdp_q   <= pdp_d;
      pv_q    <= pv_d;
      fs_q    <= fs_d;
    end
  end
  // slot sequencing, pending-load capture and frame-boundary display update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    disp_d  = disp_q;
    dp_d    = dp_q;
    pend_d  = pend_q;
    pdp_d   = pdp_q;
    pv_d    = pv_q;
    fs_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (load) begin
        state_d = ST_SHOW;
        idx_d   = '0;
        div_d   = '0;
        disp_d  = bcd_in;
        dp_d    = dp_in;
        fs_d    = 1'b1;
      end
      ST_SHOW: begin
        state_d = end_show ? ST_GUARD : ST_SHOW;
        div_d   = end_show ? '0 : div_q + CW'(1);
      end
      ST_GUARD: begin
        state_d = end_guard ? ST_SHOW : ST_GUARD;
        div_d   = end_guard ? '0 : div_q + CW'(1);
        idx_d   = !end_guard ? idx_q : wrap ? '0 : idx_q + IW'(1);
        fs_d    = boundary;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && load && !boundary) begin
      pend_d = bcd_in;
      pdp_d  = dp_in;
      pv_d   = 1'b1;
    end
    if (boundary && (load || pv_q)) begin
      disp_d = load ? bcd_in : pend_q;
      dp_d   = load ? dp_in : pdp_q;
      pv_d   = 1'b0;
    end
  end
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
    assign nibs[i] = disp_q[4*i +: 4];
  end
  lead_zero_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lzm (
    .disp_i  (disp_q),
    .dp_i    (dp_q),
    .blank_o (zmask)
  );
  assign lit         = (state_q == ST_SHOW) && !((LEAD_BLANK != 0) && zmask[idx_q]);
  assign bcd_out     = nibs[idx_q];
  assign seg_out     = lit ? seg_in : 7'd0;
  assign dp_out      = lit & dp_q[idx_q];
  assign an_out      = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  assign frame_start = fs_q;
endmodule
